vram_write_scheduler: RTL and testbench
=======================================

// Module: vram_write_scheduler
// PURPOSE
//  Queues CPU VRAM writes and issues them to text/foreground/background VRAM only while
//  video_timing reports the writable window (vblank), so the display never reads mid-update.
//  Sits between the CPU bus decode and the gpu VRAM write ports; sources the gated vram_wen.
//  Preserves write order.
//  Reports queue depth, full and a sticky overflow flag for an IRQ/status register.
// PARAMETERS
//  DEPTH   16  queue entries; power of two, 2..64
// PORTS
//  gpu_clk           in   1                 sole clock; all inputs are synchronous to it
//  rst               in   1                 synchronous, active-high reset
//  wen_i             in   1                 CPU write strobe, one-cycle pulse per write
//  SELECT_vram_i     in   1                 address decodes to VRAM; write counts only if wen_i && SELECT_vram_i
//  vram_address_i    in   vram_address_t    CPU write address
//  data_i            in   data_t            CPU write data
//  writable_i        in   1                 from video_timing; high = VRAM may be written
//  clr_overflow_i    in   1                 clears overflow_o
//  vram_wen_o        out  1                 registered write strobe to VRAM blocks
//  vram_address_o    out  vram_address_t    registered address paired with vram_wen_o
//  data_o            out  data_t            registered data paired with vram_wen_o
//  count_o           out  $clog2(DEPTH)+1   occupied entries
//  full_o            out  1                 count_o == DEPTH
//  overflow_o        out  1                 sticky: a write was dropped
// BEHAVIOUR
//  Reset: vram_wen_o=0, vram_address_o=0, data_o=0, count_o=0, full_o=0, overflow_o=0, state=HOLD.
//  Reset discards queued entries; a write accepted in the reset cycle is dropped.
//  Accept: cycle with wen_i&&SELECT_vram_i; enqueued at tail unless full.
//  Full: the write is dropped and overflow_o is set next cycle.
//  overflow_o stays set until clr_overflow_i; clr wins over a same-cycle new overflow.
//  FSM (next state decided each cycle from writable_i and count after this cycle's pop):
//   HOLD : writable_i=0; no issue. ->DRAIN if writable_i&&count>0; ->PASS if writable_i&&count==0.
//   DRAIN: pop head each cycle; drives vram_*_o next cycle.
//          ->HOLD when writable_i=0; ->PASS when the last entry pops.
//   PASS : queue empty; an accepted write is issued directly.
//          No enqueue; vram_*_o next cycle, 1-cycle latency. ->HOLD when writable_i=0.
//  Issue rule: entry/write leaves only in a cycle where writable_i=1.
//   Its strobe appears the following cycle even if writable_i has fallen.
//   video_timing guarantees >=1 cycle margin.
//  At most one VRAM write per cycle. vram_wen_o is high for exactly one cycle per issued entry.
//   Address/data are held until the next issue.
//  DRAIN + simultaneous CPU write: pop head and push tail in the same cycle; count is unchanged.
//   A full queue accepts in that cycle (slot freed).
//  writable_i falls mid-drain: the remaining entries stay queued in order; resume next window.
//  Pointers wrap modulo DEPTH; count_o is an explicit counter, not a pointer difference.
// CONFIGURATION
//  VRAM_WSCHED_COALESCE_EN defined:
//   an accepted write whose address equals the tail entry's address (queue non-empty)
//   overwrites the tail data in place; count does not change; never drops for full.
//   An entry being popped in the same cycle is not coalesced into; the write enqueues normally.
//  Undefined: every accepted write occupies its own entry.
// STRUCTURE
//  mapache64 package: wsched_entry_t {vram_address_t addr; data_t data;}.
//   Also wsched_state_e {HOLD,DRAIN,PASS}.
//  Sub-module vram_wfifo: synchronous FIFO of wsched_entry_t.
//   push/pop/full/empty/count, with tail-overwrite port (used only under the macro).
//  Top holds the FSM, issue registers and overflow flag.
//  gpu ties vram_wen to vram_wen_o and muxes address/data to the VRAM blocks.
// TESTING
//  1 writable_i=0, 3 writes (0x0100/0xAA, 0x0101/0xBB, 0x0102/0xCC)
//    -> no vram_wen_o; count_o=3.
//    Raise writable_i -> strobes on 3 consecutive cycles, in order; count_o=0; state PASS.
//  2 writable_i=0, DEPTH+1 writes
//    -> full_o after DEPTH; last write dropped; overflow_o=1.
//    clr_overflow_i -> overflow_o=0 next cycle.
//  3 PASS, write 0x0200/0x5A -> vram_wen_o=1 with 0x0200/0x5A exactly one cycle later; count_o stays 0.
//  4 8 queued, writable_i high 3 cycles then low
//    -> exactly 3 strobes, count_o=5.
//    Next window drains entries 4..8 in order.
//  5 DRAIN with full queue plus a CPU write the same cycle -> accepted, count_o unchanged, no overflow.
//  6 COALESCE_EN: writable_i=0, writes 0x0300/0x11 then 0x0300/0x22
//    -> count_o=1; drain issues 0x0300/0x22 once.
//    Without the macro: two strobes, 0x11 then 0x22.

Source files
------------

// File: rtl/vram_write_scheduler_pkg.sv
// Shared types for the VRAM write scheduler.
// Entry bundle, address/data widths and FSM states.
package vram_write_scheduler_pkg;

  typedef logic [15:0] vram_address_t;
  typedef logic [7:0]  data_t;

  typedef struct packed {
    vram_address_t addr;
    data_t         data;
  } wsched_entry_t;

  typedef enum logic [1:0] {
    HOLD,
    DRAIN,
    PASS
  } wsched_state_e;

endpackage

// File: rtl/vram_write_scheduler_wfifo.sv
// vram_wfifo: synchronous FIFO of wsched_entry_t with
// an explicit occupancy counter and a tail-overwrite port.
module vram_wfifo
  import vram_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          gpu_clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          ovr,
  input  wsched_entry_t wdata,
  output wsched_entry_t head,
  output wsched_entry_t tail,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wsched_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tl_ptr;

  assign tl_ptr = wr_ptr - AW'(1);

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge gpu_clk) begin
    if (push)     mem[wr_ptr] <= wdata;
    else if (ovr) mem[tl_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign tail  = mem[tl_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/vram_write_scheduler.sv
// Queues CPU VRAM writes and releases them only in the writable window.
// Define VRAM_WSCHED_COALESCE_EN to merge same-address writes into the tail.
module vram_write_scheduler
  import vram_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          gpu_clk,
  input  logic          rst,
  input  logic          wen_i,
  input  logic          SELECT_vram_i,
  input  vram_address_t vram_address_i,
  input  data_t         data_i,
  input  logic          writable_i,
  input  logic          clr_overflow_i,
  output logic          vram_wen_o,
  output vram_address_t vram_address_o,
  output data_t         data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          overflow_o
);

  wsched_state_e state_q;
  wsched_state_e state_d;

  wsched_entry_t in_entry;
  wsched_entry_t head;
  wsched_entry_t tail;
  wsched_entry_t issue_entry;

  logic          accept;
  logic          pop;
  logic          push;
  logic          bypass;
  logic          hit;
  logic          drop;
  logic          issue;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [CW-1:0] cnt_next;

  assign accept   = wen_i && SELECT_vram_i;
  assign in_entry = '{addr: vram_address_i, data: data_i};

  assign pop    = (state_q == DRAIN) && writable_i && !q_empty;
  assign bypass = (state_q == PASS) && writable_i && accept;

`ifdef VRAM_WSCHED_COALESCE_EN
  // A tail that leaves this cycle cannot absorb the write.
  assign hit = accept && !bypass && !q_empty &&
               (tail.addr == vram_address_i) &&
               !(pop && q_count == CW'(1));
`else
  assign hit = 1'b0;
  wire unused_tail = ^tail;
`endif

  assign push = accept && !bypass && !hit && (!q_full || pop);
  assign drop = accept && !bypass && !hit && q_full && !pop;

  assign issue       = pop || bypass;
  assign issue_entry = bypass ? in_entry : head;
  assign cnt_next    = q_count + CW'(push) - CW'(pop);

  vram_wfifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .gpu_clk(gpu_clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .ovr    (hit),
    .wdata  (in_entry),
    .head   (head),
    .tail   (tail),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD, DRAIN, PASS: begin
        if (!writable_i)          state_d = HOLD;
        else if (cnt_next == '0)  state_d = PASS;
        else                      state_d = DRAIN;
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      state_q        <= HOLD;
      vram_wen_o     <= 1'b0;
      vram_address_o <= '0;
      data_o         <= '0;
      overflow_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vram_wen_o <= issue;
      if (issue) begin
        vram_address_o <= issue_entry.addr;
        data_o         <= issue_entry.data;
      end
      if (clr_overflow_i) overflow_o <= 1'b0;
      else if (drop)      overflow_o <= 1'b1;
    end
  end

  assign count_o = q_count;
  assign full_o  = q_full;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: vector table plus
// hand sequences for overflow, split windows, full drain and coalescing.
module tb_vram_write_scheduler;

  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          gpu_clk = 1'b0;
  logic          rst;
  logic          wen_i;
  logic          SELECT_vram_i;
  logic [15:0]   vram_address_i;
  logic [7:0]    data_i;
  logic          writable_i;
  logic          clr_overflow_i;
  logic          vram_wen_o;
  logic [15:0]   vram_address_o;
  logic [7:0]    data_o;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          overflow_o;

  int checks = 0;
  int passed = 0;

  vram_write_scheduler #(
    .DEPTH(DEPTH)
  ) dut (
    .gpu_clk       (gpu_clk),
    .rst           (rst),
    .wen_i         (wen_i),
    .SELECT_vram_i (SELECT_vram_i),
    .vram_address_i(vram_address_i),
    .data_i        (data_i),
    .writable_i    (writable_i),
    .clr_overflow_i(clr_overflow_i),
    .vram_wen_o    (vram_wen_o),
    .vram_address_o(vram_address_o),
    .data_o        (data_o),
    .count_o       (count_o),
    .full_o        (full_o),
    .overflow_o    (overflow_o)
  );

  always #5 gpu_clk = ~gpu_clk;

  typedef struct {
    logic        wen;
    logic        sel;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wr;
    logic        clr;
    logic        e_wen;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    int          e_cnt;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t tv [12];

  task automatic drive(input logic w, input logic s,
                       input logic [15:0] a, input logic [7:0] d,
                       input logic wr, input logic c);
    wen_i          = w;
    SELECT_vram_i  = s;
    vram_address_i = a;
    data_i         = d;
    writable_i     = wr;
    clr_overflow_i = c;
  endtask

  task automatic idle(input logic wr);
    drive(1'b0, 1'b0, 16'h0, 8'h0, wr, 1'b0);
  endtask

  task automatic step;
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic exp_out(input string tag, input logic w,
                         input logic [15:0] a, input logic [7:0] d,
                         input int c, input logic f, input logic o);
    chk({tag, ".wen"},  32'(vram_wen_o),     32'(w));
    chk({tag, ".addr"}, 32'(vram_address_o), 32'(a));
    chk({tag, ".data"}, 32'(data_o),         32'(d));
    chk({tag, ".cnt"},  32'(count_o),        32'(c));
    chk({tag, ".full"}, 32'(full_o),         32'(f));
    chk({tag, ".ovf"},  32'(overflow_o),     32'(o));
  endtask

  // A write presented during reset must be discarded.
  task automatic do_reset;
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0999, 8'h99, 1'b0, 1'b0);
    step;
    step;
    rst = 1'b0;
    idle(1'b0);
  endtask

  initial begin
    tv[0]  = '{1, 0, 16'h0100, 8'hAA, 0, 0, 0, 16'h0000, 8'h00, 0, 0, 0};
    tv[1]  = '{1, 1, 16'h0100, 8'hAA, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0};
    tv[2]  = '{1, 1, 16'h0101, 8'hBB, 0, 0, 0, 16'h0000, 8'h00, 2, 0, 0};
    tv[3]  = '{1, 1, 16'h0102, 8'hCC, 0, 0, 0, 16'h0000, 8'h00, 3, 0, 0};
    tv[4]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 0, 16'h0000, 8'h00, 3, 0, 0};
    tv[5]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 1, 16'h0100, 8'hAA, 2, 0, 0};
    tv[6]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 1, 16'h0101, 8'hBB, 1, 0, 0};
    tv[7]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 1, 16'h0102, 8'hCC, 0, 0, 0};
    tv[8]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 0, 16'h0102, 8'hCC, 0, 0, 0};
    tv[9]  = '{1, 1, 16'h0200, 8'h5A, 1, 0, 1, 16'h0200, 8'h5A, 0, 0, 0};
    tv[10] = '{0, 0, 16'h0000, 8'h00, 1, 0, 0, 16'h0200, 8'h5A, 0, 0, 0};
    tv[11] = '{1, 1, 16'h0201, 8'h5B, 0, 0, 0, 16'h0200, 8'h5A, 1, 0, 0};

    do_reset;
    exp_out("reset", 0, 16'h0, 8'h0, 0, 0, 0);
    step;
    exp_out("post_reset", 0, 16'h0, 8'h0, 0, 0, 0);

    foreach (tv[i]) begin
      drive(tv[i].wen, tv[i].sel, tv[i].addr, tv[i].data,
            tv[i].wr, tv[i].clr);
      step;
      exp_out($sformatf("vec%0d", i), tv[i].e_wen, tv[i].e_addr,
              tv[i].e_data, tv[i].e_cnt, tv[i].e_full, tv[i].e_ovf);
    end

    // Fill to DEPTH, overflow, clear, then clear beating a new drop.
    do_reset;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 16'h0400 + 16'(i), 8'(i), 0, 0);
      step;
      exp_out($sformatf("fill%0d", i), 0, 16'h0, 8'h0, i + 1,
              i == DEPTH - 1, 0);
    end
    drive(1, 1, 16'h04FF, 8'hEE, 0, 0);
    step;
    exp_out("ovf_set", 0, 16'h0, 8'h0, DEPTH, 1, 1);
    idle(1'b0);
    step;
    exp_out("ovf_sticky", 0, 16'h0, 8'h0, DEPTH, 1, 1);
    drive(0, 0, 16'h0, 8'h0, 0, 1);
    step;
    exp_out("ovf_clr", 0, 16'h0, 8'h0, DEPTH, 1, 0);
    drive(1, 1, 16'h04FE, 8'hEF, 0, 1);
    step;
    exp_out("clr_wins", 0, 16'h0, 8'h0, DEPTH, 1, 0);

    // Drain a full queue while a CPU write arrives in the same cycle.
    idle(1'b1);
    step;
    exp_out("full_enter", 0, 16'h0, 8'h0, DEPTH, 1, 0);
    drive(1, 1, 16'h0500, 8'h77, 1, 0);
    step;
    exp_out("full_pushpop", 1, 16'h0400, 8'h00, DEPTH, 1, 0);
    for (int i = 1; i < DEPTH; i++) begin
      idle(1'b1);
      step;
      exp_out($sformatf("drain%0d", i), 1, 16'h0400 + 16'(i),
              8'(i), DEPTH - i, 0, 0);
    end
    idle(1'b1);
    step;
    exp_out("drain_last", 1, 16'h0500, 8'h77, 0, 0, 0);
    step;
    exp_out("drain_done", 0, 16'h0500, 8'h77, 0, 0, 0);

    // Window closes after three pops; remainder drains next window.
    do_reset;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 16'h0600 + 16'(i), 8'h10 + 8'(i), 0, 0);
      step;
    end
    exp_out("split_q8", 0, 16'h0, 8'h0, 8, 0, 0);
    idle(1'b1);
    step;
    exp_out("split_enter", 0, 16'h0, 8'h0, 8, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step;
      exp_out($sformatf("split_a%0d", k), 1, 16'h0600 + 16'(k),
              8'h10 + 8'(k), 7 - k, 0, 0);
    end
    idle(1'b0);
    step;
    exp_out("split_close", 0, 16'h0602, 8'h12, 5, 0, 0);
    step;
    exp_out("split_hold", 0, 16'h0602, 8'h12, 5, 0, 0);
    idle(1'b1);
    step;
    exp_out("split_reenter", 0, 16'h0602, 8'h12, 5, 0, 0);
    for (int k = 3; k < 8; k++) begin
      step;
      exp_out($sformatf("split_b%0d", k), 1, 16'h0600 + 16'(k),
              8'h10 + 8'(k), 7 - k, 0, 0);
    end
    step;
    exp_out("split_end", 0, 16'h0607, 8'h17, 0, 0, 0);

    // Same-address writes while held.
    do_reset;
    drive(1, 1, 16'h0300, 8'h11, 0, 0);
    step;
    drive(1, 1, 16'h0300, 8'h22, 0, 0);
    step;
`ifdef VRAM_WSCHED_COALESCE_EN
    exp_out("coal_q", 0, 16'h0, 8'h0, 1, 0, 0);
    idle(1'b1);
    step;
    step;
    exp_out("coal_issue", 1, 16'h0300, 8'h22, 0, 0, 0);
    step;
    exp_out("coal_once", 0, 16'h0300, 8'h22, 0, 0, 0);
`else
    exp_out("coal_q", 0, 16'h0, 8'h0, 2, 0, 0);
    idle(1'b1);
    step;
    step;
    exp_out("coal_first", 1, 16'h0300, 8'h11, 1, 0, 0);
    step;
    exp_out("coal_second", 1, 16'h0300, 8'h22, 0, 0, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
